fetch_unit: RTL

Front-end stage directly upstream of dispatch. Holds the PC, issues one instruction-memory read at a time, and buffers returned words with their PCs in a small FIFO. Presents the FIFO head to dispatch as the fetch bundle, stalls on dispatch `freeze`, and redirects and flushes on dispatch `jump` or execute `branch_miss`.

---
 rtl/fetch_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC plus one-outstanding imem fetch into a FIFO feeding dispatch.
// Define FETCH_BYPASS_EN to forward an ihit word straight to dispatch when the queue is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  output logic                        imem_ren,
  output logic [31:0]                 imem_addr,
  input  logic [31:0]                 imem_rdata,
  input  logic                        ihit,
  input  logic                        freeze,
  input  logic                        jump,
  input  logic [31:0]                 jump_target,
  input  logic                        branch_miss,
  input  logic [31:0]                 branch_target,
  output logic                        fetch_valid,
  output logic [31:0]                 fetch_instr,
  output logic [31:0]                 fetch_pc,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);
  typedef enum logic [1:0] {RUN, FULL, HALT} state_t;
  state_t          r_state;
  logic            r_live;
  logic [31:0]     r_pc;
  logic [31:0]     r_instr [FQ_DEPTH];
  logic [31:0]     r_ipc   [FQ_DEPTH];
  logic [AW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_count;
  logic            w_redirect, w_hit, w_halt, w_byp, w_enq, w_pop;
  logic [31:0]     w_target;
  assign w_redirect  = branch_miss | jump;
  assign w_target    = branch_miss ? branch_target : jump_target;
  // r_live keeps the request low for the first cycle out of reset
  assign imem_ren    = r_live && r_state == RUN && r_count < FULL_CNT;
  assign imem_addr   = r_pc;
  assign w_hit       = imem_ren && ihit && !w_redirect;
  assign w_halt      = w_hit && imem_rdata == '1;
`ifdef FETCH_BYPASS_EN
  assign w_byp       = w_hit && r_count == '0;
`else
  assign w_byp       = 1'b0;
`endif
  assign fetch_valid = r_count != '0 || w_byp;
  assign fetch_instr = r_count != '0 ? r_instr[r_rd] : w_byp ? imem_rdata : '0;
  assign fetch_pc    = r_count != '0 ? r_ipc[r_rd] : w_byp ? r_pc : '0;
  assign fq_count    = r_count;
  assign w_pop       = r_count != '0 && !freeze && !w_redirect;
  assign w_enq       = w_hit && !(w_byp && !freeze);
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_instr[r_wr] <= imem_rdata;
      r_ipc[r_wr]   <= r_pc;
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= RUN;
      r_live  <= 1'b0;
      r_pc    <= RESET_PC;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_state <= RUN;
      r_live  <= 1'b1;
      r_pc    <= w_target;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_live  <= 1'b1;
      r_wr    <= w_enq ? r_wr + AW'(1) : r_wr;
      r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
      r_pc    <= w_hit && !w_halt ? r_pc + 32'd4 : r_pc;
      r_state <= w_halt ? HALT :
                 r_state == FULL && w_pop ? RUN :
                 r_state == RUN && w_enq && !w_pop && r_count == FULL_CNT - CW'(1) ? FULL :
                 r_state;
    end
  end
endmodule
